// File: rtl/spike_rate_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_rate_encoder_pkg                                        |
// | Description : Shared float32 field layout, Q16.16 format and FSM encoding.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package spike_rate_encoder_pkg;

  localparam int FP_EXP_W      = 8;
  localparam int FP_MAN_W      = 23;
  localparam int FP_BIAS       = 127;
  localparam int Q_FRAC_W      = 16;
  localparam int UNDERFLOW_EXP = 111;

  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL = '1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } float32_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spike_rate_encoder_float_to_q16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : float_to_q16                                                  |
// | Description : Combinational float32 to saturating unsigned Q16.16.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module float_to_q16
  import spike_rate_encoder_pkg::*;
(
  input  logic [31:0] f_i,
  input  logic [31:0] cap_i,
  output logic [31:0] q_o
);

  // Exponent at which the 24-bit significand already sits at Q16.16 scale.
  localparam int SHIFT_ZERO = FP_BIAS + FP_MAN_W - Q_FRAC_W;
  localparam int MAX_LSHIFT = 32 - (FP_MAN_W + 1);

  float32_t          f;
  logic [FP_MAN_W:0] mant;
  logic [31:0]       mag;
  logic [7:0]        lsh;
  logic [7:0]        rsh;

  assign f    = f_i;
  assign mant = {1'b1, f.man};

  always_comb begin
    mag = '0;
    lsh = '0;
    rsh = '0;
    q_o = '0;
    if (f.sign) begin
      q_o = '0;
    end else if (f.exp == EXP_SPECIAL) begin
      q_o = cap_i;
    end else if (int'(f.exp) < UNDERFLOW_EXP) begin
      q_o = '0;
    end else if (int'(f.exp) > SHIFT_ZERO + MAX_LSHIFT) begin
      q_o = cap_i;
    end else begin
      if (int'(f.exp) >= SHIFT_ZERO) begin
        lsh = f.exp - 8'(SHIFT_ZERO);
        mag = {8'b0, mant} << lsh;
      end else begin
        rsh = 8'(SHIFT_ZERO) - f.exp;
        mag = {8'b0, mant} >> rsh;
      end
      q_o = (mag > cap_i) ? cap_i : mag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spike_rate_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spike_rate_encoder                                            |
// | Description : Phase-accumulating rate-to-spike encoder with window counts.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int LOG2_WIN = 10
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] rate_in,
  input  logic        rate_valid,
  output logic        spike_out,
  output logic [31:0] spike_cnt_out,
  output logic        cnt_valid,
  output logic        busy
);

  localparam int                  ACC_W    = 17 + LOG2_WIN;
  localparam logic [31:0]         RATE_CAP = 32'd1 << (Q_FRAC_W + LOG2_WIN);
  localparam logic [ACC_W-1:0]    PHASE_T  = ACC_W'(1) << (Q_FRAC_W + LOG2_WIN);
  localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;

  state_t              state_q,    state_d;
  logic [ACC_W-1:0]    acc_q,      acc_d;
  logic [LOG2_WIN-1:0] win_cnt_q,  win_cnt_d;
  logic [31:0]         spk_cnt_q,  spk_cnt_d;
  logic [ACC_W-1:0]    active_q,   active_d;
  logic [ACC_W-1:0]    pending_q,  pending_d;
  logic                pend_vld_q, pend_vld_d;
  logic                spike_q,    spike_d;
  logic [31:0]         cnt_out_q,  cnt_out_d;
  logic                cnt_vld_q,  cnt_vld_d;

  logic [31:0]         rate_conv;
  logic [ACC_W-1:0]    rate_trunc;
  logic [ACC_W-1:0]    sum;
  logic                spike_now;

  float_to_q16 u_float_to_q16 (
    .f_i   (rate_in),
    .cap_i (RATE_CAP),
    .q_o   (rate_conv)
  );

  // The clamp keeps every converted rate below 2^ACC_W, so upper bits are zero.
  assign rate_trunc = rate_conv[ACC_W-1:0];

  generate
    if (ACC_W < 32) begin : g_rate_hi
      logic unused_rate_hi;
      assign unused_rate_hi = ^rate_conv[31:ACC_W];
    end
  endgenerate

  assign sum       = acc_q + active_q;
  assign spike_now = (sum >= PHASE_T);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    win_cnt_d  = win_cnt_q;
    spk_cnt_d  = spk_cnt_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    spike_d    = 1'b0;
    cnt_out_d  = cnt_out_q;
    cnt_vld_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rate_valid) begin
          active_d   = rate_trunc;
          pend_vld_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        if (rate_valid) begin
          pending_d  = rate_trunc;
          pend_vld_d = 1'b1;
        end
        if (en) begin
          acc_d   = spike_now ? (sum - PHASE_T) : sum;
          spike_d = spike_now;
          if (win_cnt_q == WIN_LAST) begin
            cnt_out_d = spk_cnt_q + 32'(spike_now);
            cnt_vld_d = 1'b1;
            spk_cnt_d = '0;
            win_cnt_d = '0;
            // A strobe on this very cycle stays pending for the next boundary.
            if (pend_vld_q) begin
              active_d   = pending_q;
              pend_vld_d = rate_valid;
            end
          end else begin
            spk_cnt_d = spk_cnt_q + 32'(spike_now);
            win_cnt_d = win_cnt_q + LOG2_WIN'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      win_cnt_q  <= '0;
      spk_cnt_q  <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      spike_q    <= 1'b0;
      cnt_out_q  <= '0;
      cnt_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      win_cnt_q  <= win_cnt_d;
      spk_cnt_q  <= spk_cnt_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      spike_q    <= spike_d;
      cnt_out_q  <= cnt_out_d;
      cnt_vld_q  <= cnt_vld_d;
    end
  end

  assign spike_out     = spike_q;
  assign spike_cnt_out = cnt_out_q;
  assign cnt_valid     = cnt_vld_q;
  assign busy          = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spike_rate_encoder                                         |
// | Description : Scoreboard bench for spike_rate_encoder with LOG2_WIN = 4.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_spike_rate_encoder;

  localparam int LOG2_WIN = 4;
  localparam int WIN      = 1 << LOG2_WIN;

  localparam logic [31:0] R_4_0  = 32'h4080_0000;
  localparam logic [31:0] R_8_0  = 32'h4100_0000;
  localparam logic [31:0] R_2_0  = 32'h4000_0000;
  localparam logic [31:0] R_0_5  = 32'h3F00_0000;
  localparam logic [31:0] R_100  = 32'h42C8_0000;
  localparam logic [31:0] R_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] R_NEG3 = 32'hC040_0000;
  localparam logic [31:0] R_DEN  = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] rate_in;
  logic        rate_valid;
  logic        spike_out;
  logic [31:0] spike_cnt_out;
  logic        cnt_valid;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spike_rate_encoder #(.LOG2_WIN(LOG2_WIN)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .rate_in       (rate_in),
    .rate_valid    (rate_valid),
    .spike_out     (spike_out),
    .spike_cnt_out (spike_cnt_out),
    .cnt_valid     (cnt_valid),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    en         = 1'b1;
    rate_valid = 1'b0;
    rate_in    = '0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_rate(input logic [31:0] r);
    rate_in    = r;
    rate_valid = 1'b1;
    tick();
    rate_valid = 1'b0;
  endtask

  // Advances until cnt_valid or budget; reports cycles taken and spike pulses seen.
  task automatic collect_window(input int budget, output int cyc, output int spikes,
                                output logic seen);
    cyc    = 0;
    spikes = 0;
    seen   = 1'b0;
    while (cyc < budget) begin
      tick();
      cyc++;
      spikes += int'(spike_out);
      if (cnt_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    en         = 1'b1;
    rate_valid = 1'b0;
    rate_in    = '0;
    tick();
    tick();
    checks++;
    if (spike_out !== 1'b0) begin errors++; $display("FAIL reset_spike got %b exp 0", spike_out); end
    checks++;
    if (spike_cnt_out !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", spike_cnt_out); end
    checks++;
    if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_cnt_valid got %b exp 0", cnt_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_rate4();
    logic [31:0] e;
    do_reset();
    start_rate(R_4_0);
    repeat (3) exp_q.push_back(32'd4);
    for (int k = 1; k <= 3 * WIN; k++) begin
      tick();
      checks++;
      if (spike_out !== ((k % 4) == 0)) begin
        errors++; $display("FAIL rate4_spike cycle %0d got %b exp %b", k, spike_out, (k % 4) == 0);
      end
      checks++;
      if (cnt_valid !== ((k % WIN) == 0)) begin
        errors++; $display("FAIL rate4_cnt_valid cycle %0d got %b exp %b", k, cnt_valid, (k % WIN) == 0);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rate4_busy cycle %0d got %b exp 1", k, busy); end
      if (cnt_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (spike_cnt_out !== e) begin
          errors++; $display("FAIL rate4_count cycle %0d got %0d exp %0d", k, spike_cnt_out, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rate4_windows left %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_half();
    int          cyc, spikes;
    logic        seen;
    logic [31:0] e;
    do_reset();
    start_rate(R_0_5);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    for (int w = 0; w < 4; w++) begin
      collect_window(WIN + 4, cyc, spikes, seen);
      checks++;
      if (!seen || exp_q.size() == 0) begin
        errors++; $display("FAIL half_window w%0d got no cnt_valid exp within %0d cycles", w, WIN + 4);
      end else begin
        e = exp_q.pop_front();
        if (spike_cnt_out !== e) begin
          errors++; $display("FAIL half_count w%0d got %0d exp %0d", w, spike_cnt_out, e);
        end
        checks++;
        if (spikes != int'(e)) begin
          errors++; $display("FAIL half_pulses w%0d got %0d exp %0d", w, spikes, e);
        end
        checks++;
        if (cyc != WIN) begin errors++; $display("FAIL half_period w%0d got %0d exp %0d", w, cyc, WIN); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] rates[2];
    int          cyc, spikes;
    logic        seen;
    logic [31:0] e;
    rates[0] = R_100;
    rates[1] = R_NAN;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      start_rate(rates[r]);
      repeat (2) exp_q.push_back(32'd16);
      for (int w = 0; w < 2; w++) begin
        collect_window(WIN + 4, cyc, spikes, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
          errors++; $display("FAIL sat_window r%0d w%0d got no cnt_valid exp strobe", r, w);
        end else begin
          e = exp_q.pop_front();
          if (spike_cnt_out !== e) begin
            errors++; $display("FAIL sat_count r%0d w%0d got %0d exp %0d", r, w, spike_cnt_out, e);
          end
          checks++;
          if (spikes != WIN) begin
            errors++; $display("FAIL sat_pulses r%0d w%0d got %0d exp %0d", r, w, spikes, WIN);
          end
        end
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] rates[2];
    int          cyc, spikes;
    logic        seen;
    logic [31:0] e;
    rates[0] = R_NEG3;
    rates[1] = R_DEN;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      start_rate(rates[r]);
      repeat (3) exp_q.push_back(32'd0);
      for (int w = 0; w < 3; w++) begin
        collect_window(WIN + 4, cyc, spikes, seen);
        checks++;
        if (!seen || exp_q.size() == 0) begin
          errors++; $display("FAIL zero_window r%0d w%0d got no cnt_valid exp strobe", r, w);
        end else begin
          e = exp_q.pop_front();
          if (spike_cnt_out !== e) begin
            errors++; $display("FAIL zero_count r%0d w%0d got %0d exp %0d", r, w, spike_cnt_out, e);
          end
          checks++;
          if (spikes != 0 || cyc != WIN) begin
            errors++; $display("FAIL zero_timing r%0d w%0d got pulses %0d period %0d exp 0 and %0d",
                               r, w, spikes, cyc, WIN);
          end
        end
      end
    end
  endtask

  task automatic test_rate_change();
    int          cyc, spikes, total, tot_spk;
    logic        seen;
    logic [31:0] e;
    do_reset();
    start_rate(R_4_0);
    exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd2); exp_q.push_back(32'd2);
    repeat (7) tick();
    rate_in = R_8_0; rate_valid = 1'b1; tick(); rate_valid = 1'b0;
    repeat (7) tick();
    rate_in = R_2_0; rate_valid = 1'b1; tick(); rate_valid = 1'b0;
    checks++;
    if (cnt_valid !== 1'b1) begin
      errors++; $display("FAIL chg_w1_strobe got %b exp 1", cnt_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (spike_cnt_out !== e) begin errors++; $display("FAIL chg_w1_count got %0d exp %0d", spike_cnt_out, e); end
    end
    for (int w = 2; w <= 3; w++) begin
      collect_window(WIN + 4, cyc, spikes, seen);
      checks++;
      if (!seen || exp_q.size() == 0) begin
        errors++; $display("FAIL chg_window w%0d got no cnt_valid exp strobe", w);
      end else begin
        e = exp_q.pop_front();
        if (spike_cnt_out !== e) begin
          errors++; $display("FAIL chg_count w%0d got %0d exp %0d", w, spike_cnt_out, e);
        end
      end
    end
    total = 0;
    tot_spk = 0;
    repeat (5) begin tick(); total++; tot_spk += int'(spike_out); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      checks++;
      if (spike_out !== 1'b0 || cnt_valid !== 1'b0) begin
        errors++; $display("FAIL freeze_outputs cycle %0d got spike %b cnt_valid %b exp 0 0", i, spike_out, cnt_valid);
      end
    end
    en = 1'b1;
    collect_window(WIN + 8, cyc, spikes, seen);
    total += cyc;
    tot_spk += spikes;
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++; $display("FAIL freeze_window got no cnt_valid exp strobe");
    end else begin
      e = exp_q.pop_front();
      if (spike_cnt_out !== e || tot_spk != int'(e)) begin
        errors++; $display("FAIL freeze_count got %0d pulses %0d exp %0d", spike_cnt_out, tot_spk, e);
      end
      checks++;
      if (total != WIN + 5) begin errors++; $display("FAIL freeze_period got %0d exp %0d", total, WIN + 5); end
    end
  endtask

  task automatic test_reset_mid();
    int          cyc, spikes;
    logic        seen;
    logic        bad;
    logic [31:0] e;
    do_reset();
    start_rate(R_4_0);
    exp_q.push_back(32'd4);
    collect_window(WIN + 4, cyc, spikes, seen);
    checks++;
    if (!seen || exp_q.size() == 0) begin
      errors++; $display("FAIL rstmid_first got no cnt_valid exp strobe");
    end else begin
      e = exp_q.pop_front();
      if (spike_cnt_out !== e) begin errors++; $display("FAIL rstmid_first got %0d exp %0d", spike_cnt_out, e); end
    end
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (spike_out !== 1'b0 || spike_cnt_out !== 32'd0 || cnt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got spike %b cnt %0d valid %b busy %b exp all 0",
                         spike_out, spike_cnt_out, cnt_valid, busy);
    end
    bad = 1'b0;
    repeat (3 * WIN) begin
      tick();
      if (spike_out !== 1'b0 || cnt_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_idle got activity exp none before new rate_valid"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rate4();
    test_half();
    test_saturate();
    test_zero();
    test_rate_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
